// File: rtl/l2_replace_ctrl.sv
// ---------------------------------------------------------------------------------------------
// l2_replace_ctrl -- L2 cache miss/replacement control FSM.
//
// Sequences a single outstanding upstream request through tag check, optional dirty-victim
// writeback and line fill. All completion signalling (mem_resp) and LRU promotion come from
// the CHECK state. After a fill the request is re-checked, hits, and completes there. This
// keeps a single point where a request retires.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   mem_read, mem_write      upstream request (level, held until mem_resp); both high = write
//   hit, hit_way             tag compare result for the addressed set
//   lru_way                  current LRU way of the addressed set
//   victim_valid/dirty       valid/dirty bits of way lru_way
//   pmem_resp                physical-memory completion pulse
//   mem_resp                 one-cycle completion pulse to upstream
//   lru_load, lru_mru        LRU update strobe and way to promote
//   way_sel                  way targeted by array strobes and writeback address mux
//   tag_load, data_load,
//   valid_set, dirty_set,
//   dirty_clr                array write strobes for way_sel
//   pmem_read, pmem_write    physical-memory requests (level, held until pmem_resp)
// ---------------------------------------------------------------------------------------------
module l2_replace_ctrl #(
    parameter int unsigned WAY_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic [WAY_W-1:0] hit_way,
    input  logic [WAY_W-1:0] lru_way,
    input  logic             victim_valid,
    input  logic             victim_dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             lru_load,
    output logic [WAY_W-1:0] lru_mru,
    output logic [WAY_W-1:0] way_sel,
    output logic             tag_load,
    output logic             data_load,
    output logic             valid_set,
    output logic             dirty_set,
    output logic             dirty_clr,
    output logic             pmem_read,
    output logic             pmem_write
);

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWriteback,
        StFill
    } state_e;

    state_e           state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;

    // A simultaneous read and write is serviced as a write.
    logic is_write;
    assign is_write = mem_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        mem_resp   = 1'b0;
        lru_load   = 1'b0;
        lru_mru    = '0;
        way_sel    = '0;
        tag_load   = 1'b0;
        data_load  = 1'b0;
        valid_set  = 1'b0;
        dirty_set  = 1'b0;
        dirty_clr  = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    state_d = StCheck;
                end
            end

            StCheck: begin
                // The request is not re-qualified here: a request dropped mid-miss still
                // completes on the post-fill hit.
                if (hit) begin
                    mem_resp = 1'b1;
                    lru_load = 1'b1;
                    lru_mru  = hit_way;
                    way_sel  = hit_way;
                    if (is_write) begin
                        data_load = 1'b1;
                        dirty_set = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    // Freeze the victim now; lru_way may move while memory is busy.
                    victim_d = lru_way;
                    if (victim_valid && victim_dirty) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StFill;
                    end
                end
            end

            StWriteback: begin
                pmem_write = 1'b1;
                way_sel    = victim_q;
                if (pmem_resp) begin
                    state_d = StFill;
                end
            end

            StFill: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    // Install the line clean; a pending write dirties it on the re-check hit.
                    tag_load  = 1'b1;
                    data_load = 1'b1;
                    valid_set = 1'b1;
                    dirty_clr = 1'b1;
                    state_d   = StCheck;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/l2_replace_ctrl.md
L2_REPLACE_CTRL -- requirements
Module: l2_replace_ctrl

Interface
REQ-001 SHALL have parameter WAY_W, default 2, meaning way-index width (4 ways); no other values supported.
REQ-002 SHALL have clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have mem_read  input  1  L2 read request from upstream, held until mem_resp.
REQ-005 SHALL have mem_write  input  1  L2 write request from upstream, held until mem_resp.
REQ-006 SHALL have hit  input  1  tag compare hit for the addressed set, combinational from the datapath.
REQ-007 SHALL have hit_way  input  WAY_W  way index that hit; valid only when hit=1.
REQ-008 SHALL have lru_way  input  WAY_W  current LRU way of the addressed set from the LRU array.
REQ-009 SHALL have victim_valid  input  1  valid bit of way lru_way.
REQ-010 SHALL have victim_dirty  input  1  dirty bit of way lru_way.
REQ-011 SHALL have pmem_resp  input  1  physical-memory completion, one-cycle pulse.
REQ-012 SHALL have mem_resp  output  1  one-cycle completion pulse to upstream.
REQ-013 SHALL have lru_load  output  1  LRU array update strobe.
REQ-014 SHALL have lru_mru  output  WAY_W  way to promote to MRU when lru_load=1.
REQ-015 SHALL have way_sel  output  WAY_W  way targeted by tag/data/valid/dirty strobes and the writeback address mux.
REQ-016 SHALL have tag_load, data_load, valid_set, dirty_set, dirty_clr  outputs  1 each  array write strobes for way_sel.
REQ-017 SHALL have pmem_read, pmem_write  outputs  1 each  physical-memory requests, level, held until pmem_resp.

Function
REQ-018 SHALL implement FSM states IDLE, CHECK, WRITEBACK, FILL.
REQ-019 IDLE: (mem_read|mem_write)=1 -> CHECK next cycle; all outputs 0.
REQ-020 CHECK on hit: same cycle, mem_resp=1, lru_load=1, lru_mru=hit_way, way_sel=hit_way; -> IDLE.
REQ-021 CHECK on hit with mem_write=1: additionally data_load=1, dirty_set=1 in that cycle.
REQ-022 CHECK on miss: latch victim=lru_way; -> WRITEBACK if victim_valid&victim_dirty, else -> FILL; no strobes, no mem_resp.
REQ-023 WRITEBACK: pmem_write=1, way_sel=victim; on pmem_resp -> FILL.
REQ-024 FILL: pmem_read=1, way_sel=victim; on pmem_resp, same cycle tag_load=data_load=valid_set=dirty_clr=1; -> CHECK.
REQ-025 After FILL, CHECK re-evaluates and SHALL hit, so LRU update and mem_resp come only from CHECK.
REQ-026 lru_load SHALL pulse exactly once per request, never in WRITEBACK/FILL.
REQ-027 Latency: hit, request sampled in IDLE cycle 0 -> mem_resp cycle 1; clean miss with pmem_resp at cycle k -> mem_resp cycle k+1.
REQ-028 victim latched in CHECK SHALL be used for all of WRITEBACK/FILL regardless of later lru_way changes.
REQ-029 pmem_resp in IDLE or CHECK SHALL be ignored.
REQ-030 Request deassertion mid-miss is illegal; the block completes the transaction anyway.
REQ-031 mem_read and mem_write both high SHALL be treated as write.

Reset
REQ-032 rst=1 SHALL force IDLE and all outputs 0 asynchronously, including mid-WRITEBACK/FILL (pmem requests drop same cycle).
REQ-033 victim register SHALL reset to 0.
REQ-034 After rst deasserts, first request SHALL behave as from IDLE.

Verification
REQ-035 Read hit, hit_way=2 -> cycle 1: mem_resp=1, lru_load=1, lru_mru=2; cycle 2 IDLE.
REQ-036 Write hit, hit_way=1 -> cycle 1: data_load=1, dirty_set=1, way_sel=1, lru_mru=1, mem_resp=1.
REQ-037 Read miss, lru_way=3, victim_valid=0, pmem_resp at cycle 5 -> pmem_read cycles 2-5, fill strobes way 3 at cycle 5, mem_resp + lru_mru=3 at cycle 6.
REQ-038 Write miss, lru_way=0, dirty victim -> pmem_write until first pmem_resp, then pmem_read until second, then write-hit strobes on way 0; lru_load pulses once.
REQ-039 lru_way changes 0->1 during FILL -> fill strobes still target way 0.
REQ-040 rst asserted during WRITEBACK -> pmem_write=0 immediately, IDLE; next read hit completes in 1 cycle.
